// File: rtl/i2cf.sv
// I2C master with command/receive FIFOs, quarter-bit divider, SCL stretching and sticky error flags.
// Latency: a queued command reaches the bus one cycle after it sits at the FIFO head while idle.
// Backpressure: none on the bus side; pushes into a full FIFO are dropped and flagged sticky.

module i2cf_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  pop_dat,
    output logic          full,
    output logic          empty,
    output logic          drop,
    output logic [CW-1:0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && !do_push;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module i2cf #(
    parameter int CMD_DEPTH = 8,
    parameter int RX_DEPTH  = 8,
    parameter int DIVW      = 16,
    parameter int DIV_RESET = 125
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stb,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        ack,
    inout  wire         scl,
    inout  wire         sda
);
    localparam int CW = $clog2(CMD_DEPTH) + 1;
    localparam int RW = $clog2(RX_DEPTH) + 1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_BIT   = 3'd2;
    localparam logic [2:0] ST_ACK   = 3'd3;
    localparam logic [2:0] ST_STOP  = 3'd4;

    logic            wr, rd, cmd_push, rx_pop, soft_rst;
    logic [2:0]      flag_clr;
    logic [2:0]      flags;
    logic [DIVW-1:0] div, qmax;
    logic            unused;

    logic [11:0]     cmd_head;
    logic            cmd_full, cmd_empty, cmd_drop, cmd_pop;
    logic [CW-1:0]   cmd_cnt;
    logic [7:0]      rx_head;
    logic            rx_full, rx_empty, rx_drop, rx_push;
    logic [RW-1:0]   rx_cnt;

    logic [2:0]      state;
    logic [1:0]      q;
    logic [DIVW-1:0] qcnt;
    logic [2:0]      bitn;
    logic [7:0]      shreg;
    logic            smp, owned, c_read, c_nack_last, c_stop;
    logic            stretch, q_end, q_tick, st_end, nack_set, busy;
    logic            scl_lo, sda_lo;
    logic [31:0]     status;

    assign wr       = stb && we;
    assign rd       = stb && !we;
    assign ack      = stb;
    assign cmd_push = wr && (addr == 2'd0);
    assign rx_pop   = rd && (addr == 2'd0);
    assign soft_rst = wr && (addr == 2'd1) && data_in[31];
    assign flag_clr = (wr && (addr == 2'd1)) ? data_in[7:5] : 3'b000;
    assign unused   = ^data_in;

    i2cf_fifo #(.W(12), .DEPTH(CMD_DEPTH), .CW(CW)) u_cmd (
        .clk(clk), .rst(rst), .flush(soft_rst),
        .push(cmd_push), .push_dat(data_in[11:0]),
        .pop(cmd_pop), .pop_dat(cmd_head),
        .full(cmd_full), .empty(cmd_empty), .drop(cmd_drop), .count(cmd_cnt)
    );

    i2cf_fifo #(.W(8), .DEPTH(RX_DEPTH), .CW(RW)) u_rx (
        .clk(clk), .rst(rst), .flush(soft_rst),
        .push(rx_push), .push_dat(shreg),
        .pop(rx_pop), .pop_dat(rx_head),
        .full(rx_full), .empty(rx_empty), .drop(rx_drop), .count(rx_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            div <= DIVW'(DIV_RESET);
        end else if (wr && (addr == 2'd2)) begin
            div <= data_in[DIVW-1:0];
        end
    end

    // flags = {rx_ovf, cmd_ovf, nack}; a set in the same cycle as a clear loses
    always_ff @(posedge clk) begin
        if (rst || soft_rst) begin
            flags <= 3'b000;
        end else begin
            flags <= (flags | {rx_drop, cmd_drop, nack_set}) & ~flag_clr;
        end
    end

    assign qmax     = (div == '0) ? DIVW'(1) : div;
    assign stretch  = (q == 2'd1) && (scl == 1'b0);
    assign q_end    = (qcnt >= qmax - DIVW'(1));
    assign q_tick   = (state != ST_IDLE) && !stretch && q_end;
    assign st_end   = q_tick && (q == 2'd3);
    assign cmd_pop  = (state == ST_IDLE) && !cmd_empty;
    assign nack_set = st_end && (state == ST_ACK) && !c_read && smp;
    assign rx_push  = st_end && (state == ST_ACK) && c_read;
    assign busy     = (state != ST_IDLE) || !cmd_empty;

    always_ff @(posedge clk) begin
        if (rst || soft_rst) begin
            state       <= ST_IDLE;
            q           <= 2'd0;
            qcnt        <= '0;
            bitn        <= 3'd0;
            shreg       <= 8'd0;
            smp         <= 1'b0;
            owned       <= 1'b0;
            c_read      <= 1'b0;
            c_nack_last <= 1'b0;
            c_stop      <= 1'b0;
        end else if (state == ST_IDLE) begin
            q    <= 2'd0;
            qcnt <= '0;
            bitn <= 3'd0;
            if (!cmd_empty) begin
                c_nack_last <= cmd_head[11];
                c_read      <= cmd_head[10];
                c_stop      <= cmd_head[9];
                shreg       <= cmd_head[7:0];
                state       <= (cmd_head[8] || !owned) ? ST_START : ST_BIT;
            end
        end else begin
            if (!stretch) begin
                if (q_end) begin
                    qcnt <= '0;
                    q    <= q + 2'd1;
                end else begin
                    qcnt <= qcnt + DIVW'(1);
                end
            end
            if (q_tick && (q == 2'd2)) begin
                smp <= sda;
            end
            // shifting at the end of q3 keeps SDA stable until SCL has been low a full quarter
            if (st_end) begin
                case (state)
                    ST_START: begin
                        owned <= 1'b1;
                        state <= ST_BIT;
                    end
                    ST_BIT: begin
                        shreg <= {shreg[6:0], smp};
                        if (bitn == 3'd7) state <= ST_ACK;
                        else              bitn  <= bitn + 3'd1;
                    end
                    ST_ACK: state <= c_stop ? ST_STOP : ST_IDLE;
                    ST_STOP: begin
                        owned <= 1'b0;
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        scl_lo = 1'b0;
        sda_lo = 1'b0;
        case (state)
            ST_IDLE: scl_lo = owned;
            ST_START: begin
                scl_lo = ((q == 2'd0) && owned) || (q == 2'd3);
                sda_lo = (q == 2'd2) || (q == 2'd3);
            end
            ST_BIT: begin
                scl_lo = (q == 2'd0) || (q == 2'd3);
                sda_lo = !c_read && !shreg[7];
            end
            ST_ACK: begin
                scl_lo = (q == 2'd0) || (q == 2'd3);
                sda_lo = c_read && !c_nack_last;
            end
            ST_STOP: begin
                scl_lo = (q == 2'd0);
                sda_lo = (q == 2'd0) || (q == 2'd1);
            end
            default: begin
                scl_lo = 1'b0;
                sda_lo = 1'b0;
            end
        endcase
    end

    assign scl = scl_lo ? 1'b0 : 1'bz;
    assign sda = sda_lo ? 1'b0 : 1'bz;

    assign status = {8'd0, 8'(rx_cnt), 8'(cmd_cnt), flags,
                     rx_empty, rx_full, cmd_empty, cmd_full, busy};

    always_comb begin
        data_out = 32'd0;
        if (rd) begin
            case (addr)
                2'd0:    data_out = rx_empty ? 32'd0 : {24'd0, rx_head};
                2'd1:    data_out = status;
                2'd2:    data_out = 32'(div);
                default: data_out = 32'd0;
            endcase
        end
    end
endmodule

// File: tb/tb_i2cf.sv
// Directed bench for i2cf: open-drain bus with pullups, a one-byte slave model and a bus monitor.
module tb_i2cf;
    logic        clk = 1'b0;
    logic        rst, stb, we;
    logic [1:0]  addr;
    logic [31:0] data_in;
    wire  [31:0] data_out;
    wire         ack;
    wire         scl, sda;

    logic tb_scl_low = 1'b0;
    logic slv_low    = 1'b0;

    pullup (scl);
    pullup (sda);
    assign scl = tb_scl_low ? 1'b0 : 1'bz;
    assign sda = slv_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2cf #(.CMD_DEPTH(8), .RX_DEPTH(8), .DIVW(16), .DIV_RESET(125)) dut (
        .clk(clk), .rst(rst), .stb(stb), .we(we), .addr(addr),
        .data_in(data_in), .data_out(data_out), .ack(ack),
        .scl(scl), .sda(sda)
    );

    int n_cmp = 0;
    int n_err = 0;

    // slave configuration, written only by the stimulus block
    logic       slv_read   = 1'b0;
    logic       slv_ack_en = 1'b1;
    logic       stretch_en = 1'b0;
    logic [7:0] slv_byte   = 8'h00;

    // monitor state, written only by the negedge process
    int   cyc = 0, starts = 0, stops = 0, rises = 0, falls = 0, hold_cnt = 0;
    logic p_scl = 1'b1, p_sda = 1'b1;
    logic [7:0] mon_byte = 8'h00;
    logic mon_ack = 1'b0;
    int   fall_cyc [16];

    always @(negedge clk) begin
        logic c_scl, c_sda;
        c_scl = scl;
        c_sda = sda;
        cyc++;
        if (hold_cnt > 0) hold_cnt--;
        if (p_scl && c_scl && p_sda && !c_sda) begin
            starts++;
            rises = 0;
            falls = 0;
        end
        if (p_scl && c_scl && !p_sda && c_sda) stops++;
        if (!p_scl && c_scl) begin
            if (rises < 8)       mon_byte = {mon_byte[6:0], c_sda};
            else if (rises == 8) mon_ack  = c_sda;
            rises++;
        end
        if (p_scl && !c_scl) begin
            if (falls < 16) fall_cyc[falls] = cyc;
            if (stretch_en && falls == 3) hold_cnt = 24;
            falls++;
            if (rises < 8)       slv_low = slv_read && !slv_byte[3'(7 - rises)];
            else if (rises == 8) slv_low = !slv_read && slv_ack_en;
            else                 slv_low = 1'b0;
        end
        tb_scl_low = (hold_cnt > 0);
        p_scl = c_scl;
        p_sda = c_sda;
    end

    logic last_ack;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        stb = 1'b1; we = 1'b1; addr = a; data_in = d;
        @(posedge clk); #1;
        stb = 1'b0; we = 1'b0;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
        stb = 1'b1; we = 1'b0; addr = a;
        #1;
        d = data_out;
        last_ack = ack;
        @(posedge clk); #1;
        stb = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output logic ok);
        logic [31:0] s;
        int i;
        ok = 1'b0;
        i = 0;
        while (i < budget && !ok) begin
            bus_rd(2'd1, s);
            if (s[0] == 1'b0) ok = 1'b1;
            i++;
        end
    endtask

    initial begin
        logic [31:0] r;
        logic ok;
        int s0, t0, n;

        rst = 1'b1; stb = 1'b0; we = 1'b0; addr = 2'd0; data_in = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // reset state
        check("rst_scl", scl, 1'b1);
        check("rst_sda", sda, 1'b1);
        check("idle_dout", data_out, 32'd0);
        check("idle_ack", ack, 1'b0);
        bus_rd(2'd1, r);
        check("rst_status", r, 32'h0000_0014);
        check("rd_ack", last_ack, 1'b1);
        bus_rd(2'd2, r);
        check("rst_div", r, 32'd125);
        bus_rd(2'd3, r);
        check("addr3_rd", r, 32'd0);
        bus_rd(2'd0, r);
        check("rx_empty_rd", r, 32'd0);

        // write 0xA5 with start+stop, slave ACKs, Q = 2
        bus_wr(2'd2, 32'd2);
        bus_rd(2'd2, r);
        check("div_wr", r, 32'd2);
        s0 = starts; t0 = stops;
        slv_read = 1'b0; slv_ack_en = 1'b1;
        bus_wr(2'd0, 32'h3A5);
        wait_idle(2000, ok);
        check("wr_done", ok, 1'b1);
        check("wr_starts", starts - s0, 1);
        check("wr_stops", stops - t0, 1);
        check("wr_byte", mon_byte, 8'hA5);
        check("wr_ackbit", mon_ack, 1'b0);
        check("wr_bit_len", fall_cyc[2] - fall_cyc[1], 8);
        check("wr_bit7_len", fall_cyc[8] - fall_cyc[7], 8);
        bus_rd(2'd1, r);
        check("wr_status", r, 32'h0000_0014);

        // same write, slave leaves ACK high -> sticky nack, then W1C
        slv_ack_en = 1'b0;
        bus_wr(2'd0, 32'h3A5);
        wait_idle(2000, ok);
        check("nk_done", ok, 1'b1);
        check("nk_ackbit", mon_ack, 1'b1);
        bus_rd(2'd1, r);
        check("nk_status", r, 32'h0000_0034);
        bus_wr(2'd1, 32'h20);
        bus_rd(2'd1, r);
        check("nk_cleared", r, 32'h0000_0014);

        // read with nack_last, slave returns 0x3C
        slv_read = 1'b1; slv_byte = 8'h3C;
        s0 = starts; t0 = stops;
        bus_wr(2'd0, 32'hF00);
        wait_idle(2000, ok);
        check("rd_done", ok, 1'b1);
        check("rd_bus_byte", mon_byte, 8'h3C);
        check("rd_master_nack", mon_ack, 1'b1);
        check("rd_stops", stops - t0, 1);
        bus_rd(2'd1, r);
        check("rd_status", r, 32'h0001_0004);
        bus_rd(2'd0, r);
        check("rd_data", r, 32'h0000_003C);
        bus_rd(2'd1, r);
        check("rd_drained", r, 32'h0000_0014);

        // slave stretches SCL by 20 cycles in q1 of bit 3
        slv_read = 1'b0; slv_ack_en = 1'b1; stretch_en = 1'b1;
        bus_wr(2'd0, 32'h35A);
        wait_idle(2000, ok);
        stretch_en = 1'b0;
        check("st_done", ok, 1'b1);
        check("st_byte", mon_byte, 8'h5A);
        check("st_bit2_len", fall_cyc[3] - fall_cyc[2], 8);
        check("st_bit3_len", fall_cyc[4] - fall_cyc[3], 28);
        bus_rd(2'd1, r);
        check("st_status", r, 32'h0000_0014);

        // slow divider, overfill the command FIFO, then soft reset mid-byte
        bus_wr(2'd2, 32'd100);
        for (int i = 0; i < 10; i++) begin
            bus_wr(2'd0, 32'h300 | i);
        end
        bus_rd(2'd1, r);
        check("ovf_status", r, 32'h0000_0853);
        n = 0;
        while (n < 2000 && scl !== 1'b0) begin
            @(posedge clk); #1;
            n++;
        end
        check("ovf_scl_low_seen", scl, 1'b0);
        repeat (50) @(posedge clk);
        #1;
        check("mid_byte_scl", scl, 1'b0);
        bus_wr(2'd1, 32'h8000_0000);
        check("srst_scl", scl, 1'b1);
        check("srst_sda", sda, 1'b1);
        bus_rd(2'd1, r);
        check("srst_status", r, 32'h0000_0014);
        bus_rd(2'd2, r);
        check("srst_div_kept", r, 32'd100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/i2cf.md
Name: i2cf

Overview:
- Parametrised successor to the register-wrapped I2C device: a self-contained I2C master with its own bit/byte engine.
- Has a command FIFO, a receive FIFO, a programmable quarter-bit divider, SCL clock-stretching support and sticky error flags.
- Sits on the processor I/O bus (stb/we/addr strobe interface) with open-drain SCL/SDA pins, so software can queue multi-byte transactions without polling per byte.

Parameters:
CMD_DEPTH, 8, command FIFO entries (power of 2, 2..128)
RX_DEPTH, 8, receive FIFO entries (power of 2, 2..128)
DIVW, 16, divider register width
DIV_RESET, 125, divider reset value (100 kHz at 50 MHz)

Ports:
clk  in  1  system clock; the only clock
rst  in  1  reset, synchronous, active-high
stb  in  1  one-cycle bus access strobe
we  in  1  1 = write, 0 = read
addr  in  2  register select
data_in  in  32  write data
data_out  out  32  read data, combinational; 0 when no read is selected
ack  out  1  equals stb (zero wait states)
scl  inout  1  open-drain; driven 0 or z, read back for stretching
sda  inout  1  open-drain; driven 0 or z, sampled for ACK/read data

Behaviour:

Registers:
- addr 0 write: push command {[11] nack_last, [10] read, [9] stop_after, [8] start_before, [7:0] tx byte}. If the command FIFO is full, the command is dropped and cmd_ovf is set.
- addr 0 read: returns {24'b0, rx head}. Pops at that edge if the FIFO is non-empty; returns 0 with no pop if empty.
- addr 1 read (status):
  - [0] busy (engine not IDLE or cmd FIFO non-empty)
  - [1] cmd full, [2] cmd empty, [3] rx full, [4] rx empty
  - [5] nack, [6] cmd_ovf, [7] rx_ovf (sticky)
  - [15:8] cmd count, [23:16] rx count, rest 0
- addr 1 write: writing 1 to bits [7:5] clears those flags. Bit [31]=1 is a soft reset: flushes both FIFOs, engine to IDLE, SCL/SDA released next cycle, flags cleared, divider kept.
- addr 2: divider, DIVW bits, zero-extended on read. Quarter period Q = max(div,1) cycles.
- addr 3: reads 0, writes ignored.

Reset:
- scl/sda = z, FIFOs empty, div = DIV_RESET, all flags 0, engine IDLE, bus not owned.

FIFO rules:
- Simultaneous push and pop on the same FIFO: both occur, count unchanged.
- Pop when empty and push when full are no-ops; a push when full sets the corresponding overflow flag.

Engine:
- States: IDLE, START, BIT, ACK, STOP. Each state lasts 4 quarters q0..q3, each Q cycles.
- IDLE: when the cmd FIFO is non-empty, pop one command. Go to START if start_before=1 or the bus is not owned (start is forced); otherwise go to BIT.
- START: q0 SDA z, SCL held at current level; q1 SDA z, SCL z; q2 SDA 0, SCL z; q3 SDA 0, SCL 0. Sets owned.
- BIT, 8 bits MSB first: q0 SCL 0, SDA = bit (z for 1 or for read); q1 SCL z; q2 SCL z, SDA sampled at the last cycle of q2; q3 SCL 0.
- ACK: write command releases SDA and samples ACK; SDA=1 sets nack and processing continues. Read command drives 0, or z if nack_last=1. Read byte is then pushed to rx; if rx is full it is dropped and rx_ovf is set.
- After ACK: go to STOP if stop_after=1, else IDLE with the bus still owned (SCL held 0).
- STOP: q0 SCL 0, SDA 0; q1 SCL z, SDA 0; q2 SCL z, SDA z; q3 idle. Clears owned, then IDLE.
- Stretching: in q1 of every state, the quarter counter holds while scl reads 0.
- Reset mid-transfer: pins released immediately, no STOP is generated.

Test Plan:
- Reset → status = 0x0000_0014, div reads 125, scl/sda = z, data_out = 0 while stb=0.
- div=2; push 0x3A5 (start+stop, write 0xA5); slave ACKs → START, then SDA bits 1,0,1,0,0,1,0,1 sampled on SCL high, each bit 8 cycles, STOP; final status nack=0, busy=0.
- Same write with slave leaving ACK high → status[5]=1; write 0x20 to addr 1 → status[5]=0.
- Push 0xF00 (start, read, nack_last, stop); slave returns 0x3C → rx count 1, addr 0 read = 0x3C, then rx empty; master releases SDA during ACK.
- Slave holds SCL low 20 cycles in q1 of bit 3 → that bit lasts 8+20 cycles; byte value still correct.
- div=100; push CMD_DEPTH+2 write commands back-to-back → cmd_ovf=1, cmd count = CMD_DEPTH. Soft reset mid-byte → FIFOs empty, pins z next cycle, busy=0.
